// File: rtl/rx2da_rd.sv
// rx2da_rd: plays bytes out of an 8192x8 RAM to a DAC at one sample every DIV clocks, after a prefill threshold.
// Build option RX2DA_RD_MIDSCALE_EN parks da_data at 0x80 on reset, underrun and idle instead of holding it.
module rx2da_rd #(
    parameter int unsigned DIV         = 16,
    parameter int unsigned START_LEVEL = 4096
) (
    input  logic        clkb,
    input  logic        reset,
    input  logic        enable,
    input  logic [12:0] wr_ptr,
    input  logic        underrun_clr,
    output logic [12:0] adb,
    output logic        ceb,
    output logic        oce,
    input  logic [7:0]  dout,
    output logic [7:0]  da_data,
    output logic        da_valid,
    output logic [12:0] level,
    output logic        underrun
);

`ifdef RX2DA_RD_MIDSCALE_EN
    localparam logic       PARK_EN = 1'b1;
    localparam logic [7:0] DA_PARK = 8'h80;
`else
    localparam logic       PARK_EN = 1'b0;
    localparam logic [7:0] DA_PARK = 8'h00;
`endif

    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [12:0] START_LVL = 13'(START_LEVEL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        PLAY    = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] div_cnt_r;
    logic [15:0] div_nxt_s;
    logic [12:0] rd_ptr_r;
    logic [12:0] level_s;
    logic        tick_s;
    logic        issue_s;
    logic        underrun_set_s;
    logic        rd_v1_r;
    logic        rd_v2_r;
    logic        da_valid_r;
    logic [7:0]  da_data_r;
    logic        underrun_r;

    // Occupancy wraps naturally in 13 bits, so no explicit modulo is needed.
    assign level_s = wr_ptr - rd_ptr_r;
    assign tick_s  = (state_r == PLAY) && (div_cnt_r == DIV_LAST);

    // Next state, read issue / underrun decision and divider next value.
    always_comb begin
        state_nxt_s    = state_r;
        issue_s        = 1'b0;
        underrun_set_s = 1'b0;
        div_nxt_s      = 16'd0;
        if (!enable) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = PREFILL;
                end
                PREFILL: begin
                    if (level_s >= START_LVL) begin
                        state_nxt_s = PLAY;
                    end else begin
                        state_nxt_s = PREFILL;
                    end
                end
                PLAY: begin
                    if (tick_s) begin
                        if (level_s == 13'd0) begin
                            underrun_set_s = 1'b1;
                            state_nxt_s    = PREFILL;
                        end else begin
                            issue_s = 1'b1;
                        end
                    end else begin
                        div_nxt_s = div_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, divider and read pointer registers.
    always_ff @(posedge clkb) begin
        if (reset) begin
            state_r   <= IDLE;
            div_cnt_r <= 16'd0;
            rd_ptr_r  <= 13'd0;
        end else begin
            state_r   <= state_nxt_s;
            div_cnt_r <= div_nxt_s;
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + 13'd1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Read pipeline; a low enable kills an in-flight read before it reaches the DAC.
    always_ff @(posedge clkb) begin
        if (reset) begin
            rd_v1_r    <= 1'b0;
            rd_v2_r    <= 1'b0;
            da_valid_r <= 1'b0;
            da_data_r  <= DA_PARK;
        end else begin
            rd_v1_r    <= issue_s;
            rd_v2_r    <= rd_v1_r && enable;
            da_valid_r <= rd_v2_r && enable;
            if (rd_v2_r && enable) begin
                da_data_r <= dout;
            end else if (PARK_EN && (!enable || underrun_set_s)) begin
                da_data_r <= DA_PARK;
            end else begin
                da_data_r <= da_data_r;
            end
        end
    end

    // Sticky underrun flag; a new underrun outranks a simultaneous clear.
    always_ff @(posedge clkb) begin
        if (reset) begin
            underrun_r <= 1'b0;
        end else if (underrun_set_s) begin
            underrun_r <= 1'b1;
        end else if (underrun_clr) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    assign adb      = rd_ptr_r;
    assign ceb      = issue_s;
    assign oce      = rd_v1_r;
    assign da_data  = da_data_r;
    assign da_valid = da_valid_r;
    assign level    = level_s;
    assign underrun = underrun_r;

endmodule

// File: tb/tb_rx2da_rd.sv
// Self-checking bench for rx2da_rd: transaction-level reference model, directed corner scenarios, random traffic.
module tb_rx2da_rd;
    localparam int DIV         = 4;
    localparam int START_LEVEL = 4096;
`ifdef RX2DA_RD_MIDSCALE_EN
    localparam bit MIDSCALE = 1'b1;
`else
    localparam bit MIDSCALE = 1'b0;
`endif
    localparam logic [7:0] PARK = MIDSCALE ? 8'h80 : 8'h00;
    localparam int M_IDLE = 0, M_PREFILL = 1, M_PLAY = 2;

    logic        clkb = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [12:0] wr_ptr = 13'd0;
    logic        underrun_clr = 1'b0;
    logic [12:0] adb;
    logic        ceb;
    logic        oce;
    logic [7:0]  dout;
    logic [7:0]  da_data;
    logic        da_valid;
    logic [12:0] level;
    logic        underrun;

    rx2da_rd #(.DIV(DIV), .START_LEVEL(START_LEVEL)) dut (
        .clkb(clkb), .reset(reset), .enable(enable), .wr_ptr(wr_ptr),
        .underrun_clr(underrun_clr), .adb(adb), .ceb(ceb), .oce(oce),
        .dout(dout), .da_data(da_data), .da_valid(da_valid),
        .level(level), .underrun(underrun)
    );

    always #5 clkb = ~clkb;

    // RAM with a pipelined output register: ceb latches, oce presents.
    logic [7:0] mem [0:8191];
    logic [7:0] ram_q;
    logic [7:0] dout_r;
    always @(posedge clkb) begin
        if (ceb) ram_q <= mem[adb];
        if (oce) dout_r <= ram_q;
    end
    assign dout = dout_r;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: playback mode, cycles spent in PLAY, one pending delivery.
    int         m_mode = M_IDLE;
    int         m_cnt = 0;
    int         m_rd = 0;
    int         m_pend_cycle = -10;
    int         m_oce_cycle = -10;
    logic [7:0] m_pend_val = 8'h00;
    logic [7:0] m_da = 8'h00;
    bit         m_under = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_known = 1'b0;

    int          n_ceb = 0;
    int          n_dv = 0;
    int          first_ceb = -1;
    int          first_dv = -1;
    logic [7:0]  first_dv_data = 8'h00;
    logic [12:0] ceb_adb_q[$];
    int          dv_cyc_q[$];
    logic [12:0] obs_adb, obs_level;
    logic        obs_ceb, obs_oce, obs_dv, obs_under;
    logic [7:0]  obs_da;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int lvl_of(input logic [12:0] wp);
        return (int'(wp) - m_rd + 8192) % 8192;
    endfunction

    function automatic bit tick_now();
        return (m_mode == M_PLAY) && ((m_cnt % DIV) == DIV - 1);
    endfunction

    task automatic model_step(input bit r, input bit en, input int lvl, input bit clr);
        bit under_set;
        under_set = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_rd = 0; m_cnt = 0; m_under = 1'b0; m_valid = 1'b0;
            m_da = PARK; m_pend_cycle = -10; m_oce_cycle = -10; m_known = 1'b1;
        end else if (!en) begin
            m_mode = M_IDLE; m_valid = 1'b0; m_pend_cycle = -10;
            if (MIDSCALE) m_da = 8'h80;
        end else begin
            m_valid = 1'b0;
            if (cyc == m_pend_cycle) begin
                m_da = m_pend_val;
                m_valid = 1'b1;
            end
            case (m_mode)
                M_IDLE: m_mode = M_PREFILL;
                M_PREFILL: if (lvl >= START_LEVEL) begin m_mode = M_PLAY; m_cnt = 0; end
                default: begin
                    if (tick_now()) begin
                        if (lvl == 0) begin
                            under_set = 1'b1;
                            m_mode = M_PREFILL;
                            if (MIDSCALE) m_da = 8'h80;
                        end else begin
                            m_pend_val = mem[m_rd];
                            m_pend_cycle = cyc + 2;
                            m_oce_cycle = cyc + 1;
                            m_rd = (m_rd + 1) % 8192;
                        end
                    end
                    m_cnt++;
                end
            endcase
        end
        if (!r) m_under = under_set ? 1'b1 : (clr ? 1'b0 : m_under);
    endtask

    task automatic run_cycle(input bit r, input bit en, input logic [12:0] wp, input bit clr);
        int lvl;
        @(negedge clkb);
        reset = r; enable = en; wr_ptr = wp; underrun_clr = clr;
        #1;
        lvl = lvl_of(wp);
        obs_adb = adb; obs_ceb = ceb; obs_oce = oce; obs_level = level;
        obs_dv = da_valid; obs_da = da_data; obs_under = underrun;
        if (m_known) begin
            check_value("adb", 32'(adb), 32'(m_rd));
            check_value("ceb", 32'(ceb), 32'(tick_now() && en && (lvl != 0)));
            check_value("oce", 32'(oce), 32'(cyc == m_oce_cycle));
            check_value("level", 32'(level), 32'(lvl));
            check_value("da_valid", 32'(da_valid), 32'(m_valid));
            check_value("da_data", 32'(da_data), 32'(m_da));
            check_value("underrun", 32'(underrun), 32'(m_under));
        end
        if (ceb === 1'b1) begin
            n_ceb++;
            ceb_adb_q.push_back(adb);
            if (first_ceb < 0) first_ceb = cyc;
        end
        if (da_valid === 1'b1) begin
            n_dv++;
            dv_cyc_q.push_back(cyc);
            if (first_dv < 0) begin first_dv = cyc; first_dv_data = da_data; end
        end
        model_step(r, en, lvl, clr);
        cyc++;
    endtask

    task automatic wait_ceb(input string tag, input logic [12:0] wp);
        int start;
        start = n_ceb;
        for (int i = 0; i < 200 && n_ceb == start; i++) run_cycle(1'b0, 1'b1, wp, 1'b0);
        check_value(tag, 32'(n_ceb - start), 32'd1);
    endtask

    initial begin
        logic [12:0] wr;
        logic [7:0]  da_hold;
        int          base;
        bit          en_r;
        bit          clr_hit;
        bit          clr_now;

        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 13'd0, 1'b0);

        // Threshold minus one must not start playback.
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b1, 13'd4095, 1'b0);
        check_value("prefill_hold", 32'(n_ceb), 32'd0);

        base = cyc;
        for (int i = 0; i < 20000 && m_rd != 4094; i++) run_cycle(1'b0, 1'b1, 13'd4096, 1'b0);
        check_value("reach_rd_4094", 32'(m_rd), 32'd4094);
        check_value("first_ceb_latency", 32'(first_ceb - base), 32'(DIV));
        check_value("first_adb", 32'(ceb_adb_q[0]), 32'd0);
        check_value("sample_latency", 32'(first_dv - first_ceb), 32'd3);
        check_value("first_sample", 32'(first_dv_data), 32'(mem[0]));
        for (int i = 1; i < 8; i++) begin
            check_value("adb_sequence", 32'(ceb_adb_q[i]), 32'(i));
            check_value("sample_period", 32'(dv_cyc_q[i] - dv_cyc_q[i-1]), 32'(DIV));
        end

        // Writer frozen two ahead of the reader: two reads then underrun.
        base = n_ceb;
        for (int i = 0; i < 100 && !m_under; i++) run_cycle(1'b0, 1'b1, 13'd4096, 1'b0);
        check_value("starve_reads", 32'(n_ceb - base), 32'd2);
        run_cycle(1'b0, 1'b1, 13'd4096, 1'b0);
        check_value("starve_underrun", 32'(obs_under), 32'd1);
        base = n_ceb;
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b1, 13'd4096, 1'b0);
        check_value("starve_no_ceb", 32'(n_ceb - base), 32'd0);

        // Refill, clear the flag, then play up to the address wrap.
        wr = 13'((m_rd + 4096) % 8192);
        run_cycle(1'b0, 1'b1, wr, 1'b1);
        run_cycle(1'b0, 1'b1, wr, 1'b0);
        check_value("underrun_cleared", 32'(obs_under), 32'd0);
        for (int i = 0; i < 20000 && m_rd != 8191; i++) run_cycle(1'b0, 1'b1, wr, 1'b0);
        check_value("reach_rd_8191", 32'(m_rd), 32'd8191);
        ceb_adb_q.delete();
        run_cycle(1'b0, 1'b1, 13'd10, 1'b0);
        check_value("wrap_level", 32'(obs_level), 32'd11);
        clr_hit = 1'b0;
        for (int i = 0; i < 200 && m_mode == M_PLAY; i++) begin
            clr_now = tick_now() && (lvl_of(13'd10) == 0);
            if (clr_now) clr_hit = 1'b1;
            run_cycle(1'b0, 1'b1, 13'd10, clr_now);
        end
        check_value("clr_collision_hit", 32'(clr_hit), 32'd1);
        run_cycle(1'b0, 1'b1, 13'd10, 1'b0);
        check_value("set_beats_clr", 32'(obs_under), 32'd1);
        check_value("wrap_reads", 32'(ceb_adb_q.size()), 32'd11);
        check_value("wrap_adb_last", 32'(ceb_adb_q[0]), 32'd8191);
        check_value("wrap_adb_zero", 32'(ceb_adb_q[1]), 32'd0);

        // Enable drops the cycle after a read is issued.
        wr = 13'((m_rd + 4096) % 8192);
        wait_ceb("wait_ceb_enable", wr);
        da_hold = MIDSCALE ? 8'h80 : m_da;
        base = n_dv;
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, wr, 1'b0);
        check_value("drop_no_valid", 32'(n_dv - base), 32'd0);
        check_value("drop_da_data", 32'(obs_da), 32'(da_hold));

        // Reset in the cycle after a read is issued.
        wr = 13'((m_rd + 4096) % 8192);
        wait_ceb("wait_ceb_reset", wr);
        base = n_dv;
        run_cycle(1'b1, 1'b1, wr, 1'b0);
        run_cycle(1'b0, 1'b0, wr, 1'b0);
        check_value("rst_adb", 32'(obs_adb), 32'd0);
        check_value("rst_ceb", 32'(obs_ceb), 32'd0);
        check_value("rst_oce", 32'(obs_oce), 32'd0);
        check_value("rst_underrun", 32'(obs_under), 32'd0);
        check_value("rst_da_data", 32'(obs_da), 32'(PARK));
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, wr, 1'b0);
        check_value("rst_no_valid", 32'(n_dv - base), 32'd0);

        // Random traffic: writer bursts, enable toggles, stray clears and resets.
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) wr = wr + 13'($urandom_range(0, 8191));
            else if ($urandom_range(0, 3) == 0) wr = wr + 13'd1;
            if ($urandom_range(0, 199) == 0) en_r = !en_r;
            run_cycle($urandom_range(0, 999) == 0, en_r, wr, $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rx2da_rd.md
RX2DA_RD -- requirements
Module: rx2da_rd

Interface
REQ-001 The block SHALL have exactly one clock and one reset. Reset is synchronous and active-high, and is named reset.
REQ-002 Parameter DIV, default 16: clkb cycles per output sample; legal range 4..65535.
REQ-003 Parameter START_LEVEL, default 4096: buffer occupancy (bytes) required before playback starts; legal range 1..8191.
REQ-004 clkb  in  1  clock; also drives RAM read port B.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  level; high = run, low = idle.
REQ-007 wr_ptr  in  13  next write address of the upstream writer, synchronous to clkb.
REQ-008 underrun_clr  in  1  one-cycle pulse; clears underrun.
REQ-009 adb  out  13  RAM read address.
REQ-010 ceb  out  1  RAM read clock enable.
REQ-011 oce  out  1  RAM output-register enable.
REQ-012 dout  in  8  RAM read data; 8192x8, pipelined output register.
REQ-013 da_data  out  8  DAC sample.
REQ-014 da_valid  out  1  one-cycle strobe; da_data is updated in the same cycle.
REQ-015 level  out  13  occupancy, computed as (wr_ptr - rd_ptr) mod 8192.
REQ-016 underrun  out  1  sticky underrun flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, PREFILL and PLAY. Every transition takes effect on a clkb edge.
REQ-018 IDLE->PREFILL when enable=1. Any state->IDLE when enable=0, which takes priority over every other transition.
REQ-019 PREFILL->PLAY when level >= START_LEVEL. On entering PLAY, the divider SHALL load 0.
REQ-020 Divider in PLAY: counts 0..DIV-1 and wraps to 0; a tick occurs in the cycle where the count equals DIV-1. The divider is held at 0 outside PLAY.
REQ-021 Tick with level != 0 (issue cycle N):
- cycle N: ceb=1, adb=rd_ptr; rd_ptr increments at the end of N, wrapping 8191->0.
- cycle N+1: oce=1.
- cycle N+2: da_data loads dout at the end of N+2.
- cycle N+3: da_valid=1.
REQ-022 ceb and oce SHALL be 0 in every other cycle. adb SHALL hold rd_ptr whenever ceb=0.
REQ-023 Tick with level == 0:
- no read is issued;
- underrun is set;
- the state goes PLAY->PREFILL;
- da_data is set per REQ-032;
- da_valid stays 0.
REQ-024 level is combinational from wr_ptr and the rd_ptr register. A wr_ptr change in the same cycle as a tick is seen by that tick's level comparison.
REQ-025 A read already issued when enable falls SHALL be discarded: no da_valid, and da_data is not updated. rd_ptr keeps its incremented value.
REQ-026 rd_ptr SHALL be retained across IDLE; only reset clears it.
REQ-027 underrun_clr clears underrun. If an underrun set and underrun_clr occur in the same cycle, the set wins.
REQ-028 The block SHALL never write the RAM. At most one read is in flight, which DIV >= 4 guarantees.

Reset
REQ-029 While reset=1, the following SHALL hold on the next edge:
- state=IDLE, rd_ptr=0, divider=0;
- pipeline valid bits cleared;
- ceb=0, oce=0, adb=0;
- da_valid=0, underrun=0;
- da_data=0x00, or 0x80 with RX2DA_RD_MIDSCALE_EN (REQ-031).
REQ-030 Reset asserted mid-read SHALL abort the read; no da_valid appears afterwards.

Configuration
REQ-031 Macro RX2DA_RD_MIDSCALE_EN, when defined:
- da_data reset value is 0x80;
- da_data loads 0x80 on underrun and on entering IDLE.
REQ-032 When RX2DA_RD_MIDSCALE_EN is undefined:
- da_data reset value is 0x00;
- da_data holds its last value on underrun and in IDLE.

Verification
REQ-033 Reset, enable=1, wr_ptr=4095 -> state stays PREFILL. wr_ptr=4096 -> PLAY. First ceb at divider count 15 with adb=0. Sample to da_valid is 3 cycles; da_data equals RAM[0].
REQ-034 PLAY with DIV=16 and data preloaded -> da_valid every 16 cycles; adb runs 0,1,2,...; ceb and oce are each high exactly 1 cycle per sample.
REQ-035 rd_ptr=8191, wr_ptr=10 -> level=11. Read at adb=8191, then the next read at adb=0.
REQ-036 wr_ptr frozen at rd_ptr+2 in PLAY -> two samples, then on the third tick underrun=1, state PREFILL, no ceb. underrun_clr in the same cycle as a later underrun -> underrun stays 1.
REQ-037 enable dropped the cycle after ceb -> no da_valid, state IDLE. da_data holds its value, or becomes 0x80 with RX2DA_RD_MIDSCALE_EN.
REQ-038 reset asserted at cycle N+1 of a read -> no da_valid. All outputs at reset values; da_data is 0x80 when built with RX2DA_RD_MIDSCALE_EN.
